stream_mux_rr: RTL and testbench

- Parametrised N-channel, W-bit stream multiplexer with per-channel valid/ready handshake and one registered output stage.
- Generalises the team's fixed 2:1/4:1/8:1 combinational muxes.
- Adds round-robin arbitration, a software-fixed select mode and backpressure.
- Sits between multiple producer streams and a single downstream consumer (bus/serialiser).

---
 rtl/stream_mux_rr.sv | 131 +++++++++++++
 tb/tb_stream_mux_rr.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel, W-bit stream multiplexer with one registered
// output stage.
//
// Arbitration modes:
//   mode=0  round-robin. The search starts at the rotating pointer and wraps.
//   mode=1  fixed select. Channel sel is granted if it is valid. A sel value
//           of N or more grants nothing.
//
// Optional build macro STREAM_MUX_PKT_LOCK_EN adds the in_last and out_last
// ports. When enabled, a beat accepted with in_last=0 locks the grant to its
// channel until that channel's last beat is accepted.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   in_data      N*W packed channel data; channel i is in [i*W +: W]
//   in_valid     per-channel valid
//   in_ready     per-channel accept; one-hot or zero; held at zero during rst
//   mode, sel    arbitration mode and fixed-mode channel
//   out_data     registered data of the selected channel
//   out_ch       index of the channel that produced out_data
//   out_valid    output register holds a beat
//   out_ready    downstream accept
//   in_last      (lock build only) per-channel end-of-packet marker
//   out_last     (lock build only) registered end-of-packet marker
module stream_mux_rr #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_ch,
    output logic            out_valid,
    input  logic            out_ready
`ifdef STREAM_MUX_PKT_LOCK_EN
    ,
    input  logic [N-1:0]    in_last,
    output logic            out_last
`endif
);

    logic [SW-1:0] ptr;
    logic [SW-1:0] gnt;
    logic [SW-1:0] ptr_next;
    logic          gnt_vld;
    logic          free;
    logic          fire;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic          locked;
    logic [SW-1:0] lock_ch;
`endif

    always_comb begin : grant_sel
        int unsigned idx;
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = 0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        // A held lock overrides both arbitration modes.
        if (locked) begin
            gnt     = lock_ch;
            gnt_vld = in_valid[lock_ch];
        end else
`endif
        if (mode) begin
            if (int'(sel) < N) begin
                if (in_valid[sel]) begin
                    gnt     = sel;
                    gnt_vld = 1'b1;
                end
            end
        end else begin
            // The first valid channel at or after ptr wins. The search wraps
            // from N-1 to 0.
            for (int unsigned k = 0; k < unsigned'(N); k++) begin
                idx = 32'(ptr) + k;
                if (idx >= unsigned'(N)) begin
                    idx = idx - unsigned'(N);
                end
                if (!gnt_vld && in_valid[idx]) begin
                    gnt     = SW'(idx);
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        free     = !out_valid || out_ready;
        fire     = gnt_vld && free;
        ptr_next = (gnt == SW'(N - 1)) ? '0 : gnt + 1'b1;
        in_ready = '0;
        if (fire && !rst) begin
            in_ready[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
            out_last  <= 1'b0;
            locked    <= 1'b0;
            lock_ch   <= '0;
`endif
        end else if (fire) begin
            out_valid <= 1'b1;
            out_data  <= in_data[gnt*W +: W];
            out_ch    <= gnt;
            ptr       <= ptr_next;
`ifdef STREAM_MUX_PKT_LOCK_EN
            out_last  <= in_last[gnt];
            locked    <= !in_last[gnt];
            lock_ch   <= gnt;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_valid;
    logic           out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic [N-1:0]   in_last;
    logic           out_last;
`endif

    stream_mux_rr #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef STREAM_MUX_PKT_LOCK_EN
        ,
        .in_last   (in_last),
        .out_last  (out_last)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  d;
        logic [SW-1:0] ch;
        logic          last;
    } beat_t;

    beat_t sb[$];
    int    mptr;
    bit    mvalid;
    bit    mlocked;
    int    mlch;
    int    n_chk;
    int    n_fail;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int model_grant();
        if (mlocked) return in_valid[mlch] ? mlch : -1;
        if (mode) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
        for (int k = 0; k < N; k++) begin
            if (in_valid[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        sb.delete();
        mptr    = 0;
        mvalid  = 1'b0;
        mlocked = 1'b0;
        mlch    = 0;
    endtask

    // One cycle: compare the current outputs against the model, then advance
    // the model and the clock. The task returns 1 time unit after the edge.
    task automatic step();
        int           g;
        bit           free;
        logic [N-1:0] exp_rdy;
        beat_t        b;
        #1;
        free    = !mvalid || out_ready;
        g       = model_grant();
        exp_rdy = '0;
        if (g >= 0 && free) exp_rdy[g] = 1'b1;
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, mvalid);
        if (mvalid) begin
            check("out_data", out_data, sb[0].d);
            check("out_ch", out_ch, sb[0].ch);
`ifdef STREAM_MUX_PKT_LOCK_EN
            check("out_last", out_last, sb[0].last);
`endif
            if (out_ready) void'(sb.pop_front());
        end
        if (g >= 0 && free) begin
            b.d    = in_data[g*W +: W];
            b.ch   = SW'(g);
            b.last = 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
            b.last  = in_last[g];
            mlocked = !in_last[g];
            mlch    = g;
`endif
            sb.push_back(b);
            mptr   = (g + 1) % N;
            mvalid = 1'b1;
        end else if (out_ready) begin
            mvalid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_rr_data();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'hA0 + 8'(i);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        model_reset();
        rst       = 1'b1;
        in_valid  = '1;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b1;
        set_rr_data();
`ifdef STREAM_MUX_PKT_LOCK_EN
        in_last = '1;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        rst = 1'b0;

        // Round-robin with all channels valid.
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_ch", out_ch, i % N);
            check("rr_data", out_data, 8'hA0 + (i % N));
        end

        // Backpressure: ch2 is next and carries 55.
        in_data[2*W +: W] = 8'h55;
        step();
        check("bp_load", out_data, 8'h55);
        out_ready = 1'b0;
        in_data[2*W +: W] = 8'h66;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold", out_data, 8'h55);
            check("bp_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        check("bp_next_ch", out_ch, 3);

        // Fixed select.
        mode = 1'b1;
        sel  = 2'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fix_ch", out_ch, 2);
        end
        in_valid = 4'b1011;
        step();
        check("fix_none", out_valid, 0);
        step();

        // Sparse wrap: ptr is 3, only ch1 valid.
        mode     = 1'b0;
        in_valid = 4'b0010;
        step();
        check("wrap_ch", out_ch, 1);
        in_valid = 4'b1100;
        step();
        check("wrap_ptr2", out_ch, 2);

`ifdef STREAM_MUX_PKT_LOCK_EN
        // Packet lock: ch1 sends three beats while ch0 stays valid.
        in_valid = 4'b0001;
        step();
        in_valid   = 4'b0011;
        in_last[1] = 1'b0;
        step();
        check("lock_ch1", out_ch, 1);
        check("lock_last1", out_last, 0);
        step();
        check("lock_ch2", out_ch, 1);
        check("lock_last2", out_last, 0);
        in_last[1] = 1'b1;
        step();
        check("lock_ch3", out_ch, 1);
        check("lock_last3", out_last, 1);
        step();
        check("lock_after", out_ch, 0);
`endif

        // Randomised traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            in_data   = $urandom;
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            mode      = ($urandom_range(0, 3) == 0);
            sel       = SW'($urandom);
`ifdef STREAM_MUX_PKT_LOCK_EN
            in_last = N'($urandom) | N'($urandom);
`endif
            step();
        end

        // Reset while a beat is pending.
        in_valid  = '1;
        mode      = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_rdy", in_ready, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        set_rr_data();
`ifdef STREAM_MUX_PKT_LOCK_EN
        in_last = '1;
`endif
        step();
        check("post_rst_ch", out_ch, 0);
        step();
        check("post_rst_ch1", out_ch, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
